// File: rtl/mbinit_sb_pkg.sv
// Shared constants for the MBINIT sideband request/response phases:
// message codes, responder state encoding and comparator-mode codes.
package mbinit_sb_pkg;

    localparam int unsigned MSG_INIT_REQ  = 1;
    localparam int unsigned MSG_INIT_RESP = 2;
    localparam int unsigned MSG_CLR_REQ   = 3;
    localparam int unsigned MSG_CLR_RESP  = 4;
    localparam int unsigned MSG_RES_REQ   = 5;
    localparam int unsigned MSG_RES_RESP  = 6;
    localparam int unsigned MSG_DONE_REQ  = 7;
    localparam int unsigned MSG_DONE_RESP = 8;

    localparam int unsigned ST_W = 3;
    localparam logic [ST_W-1:0] ST_IDLE        = 3'd0;
    localparam logic [ST_W-1:0] ST_WAIT_INIT   = 3'd1;
    localparam logic [ST_W-1:0] ST_WAIT_REQ    = 3'd2;
    localparam logic [ST_W-1:0] ST_WAIT_SECOND = 3'd3;
    localparam logic [ST_W-1:0] ST_WAIT_BUSY   = 3'd4;
    localparam logic [ST_W-1:0] ST_SEND        = 3'd5;
    localparam logic [ST_W-1:0] ST_DONE        = 3'd6;
    localparam logic [ST_W-1:0] ST_TIMEOUT     = 3'd7;

    localparam int unsigned CMP_W = 2;
    localparam logic [CMP_W-1:0] CMP_IDLE  = 2'b00;
    localparam logic [CMP_W-1:0] CMP_CLEAR = 2'b01;
    localparam logic [CMP_W-1:0] CMP_HOLD  = 2'b11;

endpackage

// File: rtl/mbinit_timeout_cnt.sv
// Per-state watchdog: counts while enabled, restarts on state change,
// and flags expiry once TIMEOUT_CYCLES cycles have elapsed in one state.
module mbinit_timeout_cnt #(
    parameter int unsigned TIMEOUT_CYCLES = 1024,
    parameter int unsigned TO_W           = 11
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_clear,
    input  logic i_count_en,
    output logic o_expire_c
);

    logic [TO_W-1:0] cnt_q;
    logic [TO_W-1:0] cnt_d;

    // Expiry depends only on the registered count, so it can steer the
    // owner's next-state logic without a combinational loop through i_clear.
    assign o_expire_c = i_count_en && (cnt_q == TO_W'(TIMEOUT_CYCLES - 1));

    always_comb begin
        cnt_d = cnt_q;
        if (i_clear) begin
            cnt_d = '0;
        end else if (i_count_en && (cnt_q != {TO_W{1'b1}})) begin
            cnt_d = cnt_q + TO_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/mbinit_partner_responder.sv
// Module-partner responder for MBINIT sideband phases: answers init, then
// clear_error / result / done requests, with repeater tracking and a watchdog.
module mbinit_partner_responder
    import mbinit_sb_pkg::*;
#(
    parameter int unsigned NUM_LANES      = 16,
    parameter int unsigned MSG_W          = 4,
    parameter int unsigned REPEAT_THRESH  = 2,
    parameter int unsigned CNT_W          = 3,
    parameter int unsigned TIMEOUT_CYCLES = 1024,
    parameter int unsigned TO_W           = 11
) (
    input  logic                 CLK,
    input  logic                 rst_n,
    input  logic                 i_enable,
    input  logic [MSG_W-1:0]     i_rx_msg,
    input  logic                 i_msg_valid,
    input  logic                 i_busy_sb,
    input  logic                 i_falling_edge_busy,
    input  logic                 i_apply_repeater,
    input  logic [NUM_LANES-1:0] i_lane_result,
    output logic [MSG_W-1:0]     o_tx_msg,
    output logic                 o_tx_valid,
    output logic                 o_data_valid,
    output logic [NUM_LANES-1:0] o_lane_result,
    output logic [1:0]           o_clear_comparator,
    output logic                 o_start_repeater,
    output logic [CNT_W-1:0]     o_clear_count,
    output logic                 o_done,
    output logic                 o_timeout
);

    logic [ST_W-1:0]      state_q, state_d;
    logic [MSG_W-1:0]     pending_code_q, pending_code_d;
    logic                 pending_res_q, pending_res_d;
    logic [NUM_LANES-1:0] lane_result_q, lane_result_d;
    logic                 start_rep_q, start_rep_d;
    logic [CNT_W-1:0]     clear_count_q, clear_count_d;
    logic [MSG_W-1:0]     tx_msg_q, tx_msg_d;
    logic                 tx_valid_q, tx_valid_d;
    logic                 data_valid_q, data_valid_d;
    logic [CMP_W-1:0]     clear_cmp_q, clear_cmp_d;
    logic                 done_q, done_d;
    logic                 timeout_q, timeout_d;

    logic                 count_en_c;
    logic                 expire_c;
    logic                 req_valid_c;
    logic                 is_clr_c, is_res_c, is_done_c, is_init_c;
    logic [CNT_W-1:0]     clear_count_inc_c;

    assign count_en_c = (state_q == ST_WAIT_INIT) || (state_q == ST_WAIT_REQ) ||
                        (state_q == ST_WAIT_SECOND) || (state_q == ST_WAIT_BUSY) ||
                        (state_q == ST_SEND);

    mbinit_timeout_cnt #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
        .TO_W           (TO_W)
    ) u_timeout_cnt (
        .clk        (CLK),
        .rst_n      (rst_n),
        .i_clear    (state_d != state_q),
        .i_count_en (count_en_c),
        .o_expire_c (expire_c)
    );

    assign req_valid_c = i_msg_valid;
    assign is_init_c   = req_valid_c && (i_rx_msg == MSG_W'(MSG_INIT_REQ));
    assign is_clr_c    = req_valid_c && (i_rx_msg == MSG_W'(MSG_CLR_REQ));
    assign is_res_c    = req_valid_c && (i_rx_msg == MSG_W'(MSG_RES_REQ));
    assign is_done_c   = req_valid_c && (i_rx_msg == MSG_W'(MSG_DONE_REQ));

    assign clear_count_inc_c = (clear_count_q == {CNT_W{1'b1}}) ? clear_count_q
                                                                : clear_count_q + CNT_W'(1);

    // Next-state, request acceptance and registered-output decode.
    always_comb begin
        state_d        = state_q;
        pending_code_d = pending_code_q;
        pending_res_d  = pending_res_q;
        lane_result_d  = lane_result_q;
        start_rep_d    = start_rep_q;
        clear_count_d  = clear_count_q;

        if (!i_enable) begin
            state_d        = ST_IDLE;
            pending_code_d = '0;
            pending_res_d  = 1'b0;
            start_rep_d    = 1'b0;
            clear_count_d  = '0;
        end else begin
            case (state_q)
                ST_IDLE: state_d = ST_WAIT_INIT;
                ST_WAIT_INIT: begin
                    if (expire_c) begin
                        state_d = ST_TIMEOUT;
                    end else if (is_init_c) begin
                        pending_code_d = MSG_W'(MSG_INIT_RESP);
                        pending_res_d  = 1'b0;
                        state_d        = ST_WAIT_BUSY;
                    end
                end
                ST_WAIT_REQ, ST_WAIT_SECOND: begin
                    if (expire_c) begin
                        state_d = ST_TIMEOUT;
                    end else if ((state_q == ST_WAIT_REQ) && i_apply_repeater) begin
                        state_d = ST_WAIT_SECOND;
                    end else if (is_clr_c) begin
                        clear_count_d  = clear_count_inc_c;
                        if (clear_count_inc_c == CNT_W'(REPEAT_THRESH)) begin
                            start_rep_d = 1'b1;
                        end
                        pending_code_d = MSG_W'(MSG_CLR_RESP);
                        pending_res_d  = 1'b0;
                        state_d        = ST_WAIT_BUSY;
                    end else if ((state_q == ST_WAIT_REQ) && is_res_c) begin
                        lane_result_d  = i_lane_result;
                        pending_code_d = MSG_W'(MSG_RES_RESP);
                        pending_res_d  = 1'b1;
                        state_d        = ST_WAIT_BUSY;
                    end else if ((state_q == ST_WAIT_REQ) && is_done_c) begin
                        pending_code_d = MSG_W'(MSG_DONE_RESP);
                        pending_res_d  = 1'b0;
                        state_d        = ST_WAIT_BUSY;
                    end
                end
                ST_WAIT_BUSY: begin
                    if (expire_c) begin
                        state_d = ST_TIMEOUT;
                    end else if (!i_busy_sb) begin
                        state_d = ST_SEND;
                    end
                end
                ST_SEND: begin
                    if (expire_c) begin
                        state_d = ST_TIMEOUT;
                    end else if (i_falling_edge_busy) begin
                        if (pending_code_q == MSG_W'(MSG_DONE_RESP)) begin
                            state_d = ST_DONE;
                        end else if (i_apply_repeater) begin
                            state_d = ST_WAIT_SECOND;
                        end else begin
                            state_d = ST_WAIT_REQ;
                        end
                    end
                end
                ST_DONE:    state_d = ST_DONE;
                ST_TIMEOUT: state_d = ST_TIMEOUT;
                default:    state_d = ST_IDLE;
            endcase
        end

        tx_valid_d   = (state_d == ST_SEND);
        tx_msg_d     = (state_d == ST_SEND) ? pending_code_d : '0;
        data_valid_d = (state_d == ST_SEND) && pending_res_d;
        done_d       = (state_d == ST_DONE);
        timeout_d    = (state_d == ST_TIMEOUT);
        if (state_d == ST_IDLE) begin
            clear_cmp_d = CMP_IDLE;
        end else if ((state_d == ST_SEND) && (pending_code_d == MSG_W'(MSG_CLR_RESP))) begin
            clear_cmp_d = CMP_CLEAR;
        end else begin
            clear_cmp_d = CMP_HOLD;
        end
    end

    always_ff @(posedge CLK or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= ST_IDLE;
            pending_code_q <= '0;
            pending_res_q  <= 1'b0;
            lane_result_q  <= '0;
            start_rep_q    <= 1'b0;
            clear_count_q  <= '0;
            tx_msg_q       <= '0;
            tx_valid_q     <= 1'b0;
            data_valid_q   <= 1'b0;
            clear_cmp_q    <= CMP_HOLD;
            done_q         <= 1'b0;
            timeout_q      <= 1'b0;
        end else begin
            state_q        <= state_d;
            pending_code_q <= pending_code_d;
            pending_res_q  <= pending_res_d;
            lane_result_q  <= lane_result_d;
            start_rep_q    <= start_rep_d;
            clear_count_q  <= clear_count_d;
            tx_msg_q       <= tx_msg_d;
            tx_valid_q     <= tx_valid_d;
            data_valid_q   <= data_valid_d;
            clear_cmp_q    <= clear_cmp_d;
            done_q         <= done_d;
            timeout_q      <= timeout_d;
        end
    end

    assign o_tx_msg           = tx_msg_q;
    assign o_tx_valid         = tx_valid_q;
    assign o_data_valid       = data_valid_q;
    assign o_lane_result      = lane_result_q;
    assign o_clear_comparator = clear_cmp_q;
    assign o_start_repeater   = start_rep_q;
    assign o_clear_count      = clear_count_q;
    assign o_done             = done_q;
    assign o_timeout          = timeout_q;

endmodule
